// File: rtl/return_addr_stack.sv
// Return-address stack for the multicycle core.
//
// CALL (push) saves the return PC, RET (pop) exposes the saved PC on top_pc for the
// PC-select mux. Both flags are qualified by aux_push_pop, a one-clock-per-instruction
// strobe; with the strobe low the stack holds its state.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset; clears pointer, count, flags and entries
//   push         decoded CALL flag
//   pop          decoded RET flag
//   aux_push_pop strobe qualifying push/pop
//   ret_pc_in    return address to save
//   top_pc       current top-of-stack entry (0 when empty), combinational
//   count        number of valid entries, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   overflow     sticky: push attempted while full (never set in circular mode)
//   underflow    sticky: pop attempted while empty
//
// Build option:
//   RAS_CIRCULAR_EN  when defined, a push while full overwrites the oldest entry
//                    instead of being dropped.
module return_addr_stack #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  aux_push_pop,
    input  logic [ADDR_WIDTH-1:0] ret_pc_in,
    output logic [ADDR_WIDTH-1:0] top_pc,
    output logic [PTR_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0]   FullCount = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PtrOne    = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   CntOne    = (PTR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  sp_q, sp_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_addr;
    logic                  is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FullCount);

    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = sp_q;
        if (aux_push_pop) begin
            if (push && pop && !is_empty) begin
                // Replace top: the RET is immediately followed by a new CALL.
                wr_en   = 1'b1;
                wr_addr = sp_q - PtrOne;
            end else if (push) begin
                // Also covers push+pop on an empty stack, which acts as a plain push.
                if (!is_full) begin
                    wr_en   = 1'b1;
                    sp_d    = sp_q + PtrOne;
                    count_d = count_q + CntOne;
                end else begin
`ifdef RAS_CIRCULAR_EN
                    // sp points at the oldest entry when full; overwrite it.
                    wr_en = 1'b1;
                    sp_d  = sp_q + PtrOne;
`else
                    overflow_d = 1'b1;
`endif
                end
            end else if (pop) begin
                if (!is_empty) begin
                    sp_d    = sp_q - PtrOne;
                    count_d = count_q - CntOne;
                end else begin
                    underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= ret_pc_in;
        end
    end

    assign top_pc    = is_empty ? '0 : mem_q[sp_q - PtrOne];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        aux_push_pop = 1'b0;
    logic [31:0] ret_pc_in = '0;
    logic [31:0] top_pc;
    logic [3:0]  count;
    logic        empty, full, overflow, underflow;

    return_addr_stack #(
        .ADDR_WIDTH(32),
        .DEPTH     (8),
        .PTR_WIDTH (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .aux_push_pop(aux_push_pop),
        .ret_pc_in   (ret_pc_in),
        .top_pc      (top_pc),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        psh;
        logic        pp;
        logic        aux;
        logic [31:0] pc;
        logic [31:0] top;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input vec_t e);
        cmp({tag, " top_pc"}, top_pc, e.top);
        cmp({tag, " count"}, 32'(count), 32'(e.cnt));
        cmp({tag, " empty"}, 32'(empty), 32'(e.cnt == 4'd0));
        cmp({tag, " full"}, 32'(full), 32'(e.cnt == 4'd8));
        cmp({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
        cmp({tag, " underflow"}, 32'(underflow), 32'(e.unf));
    endtask

    function automatic vec_t mk(input logic p, input logic q, input logic a,
                                input logic [31:0] pc, input logic [31:0] top,
                                input logic [3:0] cnt, input logic ovf, input logic unf);
        vec_t v;
        v.psh = p; v.pp = q; v.aux = a; v.pc = pc;
        v.top = top; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Drive one cycle of stimulus at negedge; expected state is queued and checked
    // just after the following rising edge.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        push = v.psh; pop = v.pp; aux_push_pop = v.aux; ret_pc_in = v.pc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s: scoreboard empty, got none, expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_state(tag, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; aux_push_pop = 1'b0;
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [31:0] exp_top;

        reset = 1'b0;
        #12;
        check_state("reset", mk(0, 0, 0, 0, 32'h0, 4'd0, 0, 0));
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step($sformatf("idle%0d", i), mk(0, 0, 0, 0, 32'h0, 4'd0, 0, 0));
        end

        // psh pp aux pc -> top cnt ovf unf
        tbl.push_back(mk(1, 0, 1, 32'h100, 32'h100, 4'd1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h200, 32'h200, 4'd2, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h300, 32'h300, 4'd3, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h200, 4'd2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h100, 4'd1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h0,   4'd0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 32'hABC, 32'h0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h55,  32'h55,  4'd1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h66,  32'h66,  4'd1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h0,   4'd0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h0,   4'd0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 32'h1,   32'h1,   4'd1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h0,   4'd0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 32'h2,   32'h2,   4'd1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 32'h3,   32'h3,   4'd2, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h2,   4'd1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h0,   32'h0,   4'd0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,   32'h0,   4'd0, 0, 1));

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        do_reset();
        check_state("flags_reset", mk(0, 0, 0, 0, 32'h0, 4'd0, 0, 0));

        // Fill to full, then push once more.
        for (int i = 1; i <= 8; i++) begin
            v = mk(1, 0, 1, 32'(i * 16), 32'(i * 16), 4'(i), 0, 0);
            step($sformatf("fill%0d", i), v);
        end
`ifdef RAS_CIRCULAR_EN
        step("push_full", mk(1, 0, 1, 32'h90, 32'h90, 4'd8, 0, 0));
        for (int j = 1; j <= 8; j++) begin
            exp_top = (j < 8) ? 32'(32'h90 - j * 16) : 32'h0;
            step($sformatf("drain%0d", j), mk(0, 1, 1, 0, exp_top, 4'(8 - j), 0, 0));
        end
`else
        step("push_full", mk(1, 0, 1, 32'h90, 32'h80, 4'd8, 1, 0));
        for (int j = 1; j <= 8; j++) begin
            exp_top = (j < 8) ? 32'(32'h80 - j * 16) : 32'h0;
            step($sformatf("drain%0d", j), mk(0, 1, 1, 0, exp_top, 4'(8 - j), 1, 0));
        end
`endif

        do_reset();
        step("rp_push", mk(1, 0, 1, 32'h40, 32'h40, 4'd1, 0, 0));
        step("rp_repl", mk(1, 1, 1, 32'h44, 32'h44, 4'd1, 0, 0));

        // Asynchronous reset between strobes, away from any clock edge.
        @(negedge clk);
        push = 1'b0; pop = 1'b0; aux_push_pop = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_state("async_reset", mk(0, 0, 0, 0, 32'h0, 4'd0, 0, 0));
        #1;
        reset = 1'b1;
        step("post_reset", mk(1, 0, 1, 32'h77, 32'h77, 4'd1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack for the multicycle core, sitting directly downstream of the ID control unit.
- Consumes the decoder's push/pop flags (CALL/RET) and the once-per-instruction push/pop strobe, which is high for exactly one clock per instruction.
- CALL saves the return PC; RET supplies the saved PC to the PC-select mux (pcSrc = 000).
- Tracks occupancy and flags overflow and underflow.

Parameters:
- ADDR_WIDTH, 32, width of the stored PC values.
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_WIDTH, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  decoded CALL flag from control unit.
- pop  input  1  decoded RET flag from control unit.
- aux_push_pop  input  1  one-cycle strobe qualifying push/pop; ignore push/pop when low.
- ret_pc_in  input  ADDR_WIDTH  return address to save (PC+1, computed upstream).
- top_pc  output  ADDR_WIDTH  current top-of-stack entry; feeds PC mux for RET.
- count  output  PTR_WIDTH+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous): sp=0, count=0, overflow=0, underflow=0, all entries cleared to 0.
- Reset outputs: top_pc=0, empty=1, full=0.
- Operations occur only on a rising clk edge where aux_push_pop=1. With aux_push_pop=0, state holds regardless of push/pop.
- Push only (push=1, pop=0):
  - Not full: mem[sp] <= ret_pc_in; sp <= sp+1; count <= count+1.
  - Full: see Optional Feature.
- Pop only (pop=1, push=0):
  - Not empty: sp <= sp-1; count <= count-1. The popped entry is not cleared.
  - Empty: no state change; underflow <= 1.
- Push and pop together: replace top.
  - Non-empty: mem[sp-1] <= ret_pc_in; sp and count unchanged.
  - Empty: treated as push only; underflow is not set.
- top_pc is combinational: mem[sp-1] when count>0, else 0.
  - A value read before the strobe edge is the pre-operation top.
  - After a push, ret_pc_in appears on top_pc in the cycle following the edge.
- sp is PTR_WIDTH bits and wraps modulo DEPTH. count is separate and saturates at 0 and DEPTH.
- empty and full are derived combinationally from count.
- overflow and underflow clear only on reset.
- Asserting reset mid-operation immediately aborts all state; the next strobe after release is processed normally.

Optional Feature:
- Macro: RAS_CIRCULAR_EN.
- Defined: push when full overwrites the oldest entry.
  - mem[sp] <= ret_pc_in; sp <= sp+1 (wraps); count stays DEPTH; overflow is never set.
  - Pops after wrap return the newest DEPTH addresses in LIFO order.
- Undefined: push when full is dropped; mem, sp and count are unchanged; overflow <= 1.

Test Plan:
- Reset, then no strobes for 10 cycles -> top_pc=0, empty=1, count=0, overflow=0, underflow=0.
- Push 0x100, 0x200, 0x300 (one strobe each) -> count=3, top_pc=0x300; three pops -> top_pc 0x200, 0x100, then 0 with empty=1.
- push=1 with aux_push_pop=0 for 4 cycles, ret_pc_in=0xABC -> count stays 0, no state change.
- Pop when empty -> underflow=1, count=0; underflow remains 1 after 5 further valid push/pop cycles until reset.
- Fill with 0x10..0x80 (8 entries), push 0x90:
  - Macro undefined -> overflow=1, top_pc=0x80, count=8.
  - Macro defined -> overflow=0, top_pc=0x90, count=8; eight pops return 0x90..0x20.
- Push 0x40, then strobe with push=pop=1 and ret_pc_in=0x44 -> count=1, top_pc=0x44. Pulse reset low between strobes -> count=0 immediately, asynchronously.
